// File: rtl/flatten_stream_ctrl.sv
// Flatten boundary controller: streams a 3D maxpool buffer to the FCL as 1D beats (forward)
// and scatters the FCL gradient stream back into a 3D buffer (backward), both channel/row/column order.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; start+mode choose the pass
// S_FWD    | issuing 3D reads and draining the skid FIFO onto the FCL stream
// S_BWD    | accepting gradient beats and issuing one 3D write per beat
module flatten_stream_ctrl #(
   parameter int WIDTH       = 16,
   parameter int CHANNELS    = 3,
   parameter int DIM3_WIDTH  = 32,
   parameter int DIM3_HEIGHT = 32,
   localparam int DIM1_LENGTH = CHANNELS * DIM3_HEIGHT * DIM3_WIDTH,
   localparam int IDX_W = $clog2(DIM1_LENGTH),
   localparam int CH_W  = (CHANNELS    > 1) ? $clog2(CHANNELS)    : 1,
   localparam int ROW_W = (DIM3_HEIGHT > 1) ? $clog2(DIM3_HEIGHT) : 1,
   localparam int COL_W = (DIM3_WIDTH  > 1) ? $clog2(DIM3_WIDTH)  : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             fwd_rd_en,
   output logic [CH_W-1:0]  fwd_rd_ch,
   output logic [ROW_W-1:0] fwd_rd_row,
   output logic [COL_W-1:0] fwd_rd_col,
   input  logic [WIDTH-1:0] fwd_rd_data,
   output logic             fcl_valid,
   input  logic             fcl_ready,
   output logic [WIDTH-1:0] fcl_data,
   output logic [IDX_W-1:0] fcl_idx,
   output logic             fcl_last,
   input  logic             grad_valid,
   output logic             grad_ready,
   input  logic [WIDTH-1:0] grad_data,
   input  logic             grad_last,
   output logic             bwd_wr_en,
   output logic [CH_W-1:0]  bwd_wr_ch,
   output logic [ROW_W-1:0] bwd_wr_row,
   output logic [COL_W-1:0] bwd_wr_col,
   output logic [WIDTH-1:0] bwd_wr_data
);

   localparam int CNT_W = $clog2(DIM1_LENGTH + 1);
   localparam logic [CNT_W-1:0] CNT_LEN  = CNT_W'(DIM1_LENGTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM1_LENGTH - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM1_LENGTH - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM3_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(DIM3_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_BWD} state_t;
   state_t state_q, state_d;

   logic [CNT_W-1:0] beat_cnt;
   logic [IDX_W-1:0] out_idx;
   logic [CH_W-1:0]  ch_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic             pending;
   logic [1:0]       count;
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr, rd_ptr;
   logic             start_ok, rd_issue, grad_acc, final_xfer;
   logic             fire, push, pop, adv, head_valid;

   always_comb begin
      state_d    = state_q;
      start_ok   = 1'b0;
      rd_issue   = 1'b0;
      grad_acc   = 1'b0;
      final_xfer = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = mode ? S_BWD : S_FWD;
            end
         end
         S_FWD: begin
            // reads in flight count against the FIFO so a stalled sink can never overflow it
            rd_issue = (beat_cnt < CNT_LEN) && ((count + {1'b0, pending}) < 2'd2);
            if (fire && (out_idx == IDX_LAST)) begin
               final_xfer = 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_BWD: begin
            grad_acc = grad_valid;
            if (grad_valid && (beat_cnt == CNT_LAST)) begin
               final_xfer = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Fall-through head: an empty FIFO presents the returning read data directly
   assign head_valid = (count != 2'd0) || pending;
   assign fcl_valid  = (state_q == S_FWD) && head_valid;
   assign fcl_data   = !fcl_valid ? '0 : ((count != 2'd0) ? mem[rd_ptr] : fwd_rd_data);
   assign fcl_idx    = out_idx;
   assign fcl_last   = fcl_valid && (out_idx == IDX_LAST);
   assign fire       = fcl_valid && fcl_ready;
   assign push       = pending && !((count == 2'd0) && fire);
   assign pop        = (count != 2'd0) && fire;
   assign adv        = rd_issue || grad_acc;

   assign busy       = (state_q != S_IDLE);
   assign grad_ready = (state_q == S_BWD);
   assign fwd_rd_en  = rd_issue;
   assign fwd_rd_ch  = ch_q;
   assign fwd_rd_row = row_q;
   assign fwd_rd_col = col_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= fwd_rd_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         done        <= 1'b0;
         err         <= 1'b0;
         beat_cnt    <= '0;
         out_idx     <= '0;
         ch_q        <= '0;
         row_q       <= '0;
         col_q       <= '0;
         pending     <= 1'b0;
         count       <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         bwd_wr_en   <= 1'b0;
         bwd_wr_ch   <= '0;
         bwd_wr_row  <= '0;
         bwd_wr_col  <= '0;
         bwd_wr_data <= '0;
      end else begin
         state_q   <= state_d;
         done      <= final_xfer;
         bwd_wr_en <= grad_acc;
         if (grad_acc) begin
            bwd_wr_ch   <= ch_q;
            bwd_wr_row  <= row_q;
            bwd_wr_col  <= col_q;
            bwd_wr_data <= grad_data;
         end
         if (start_ok) begin
            err      <= 1'b0;
            beat_cnt <= '0;
            out_idx  <= '0;
            ch_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pending  <= 1'b0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
         end else begin
            pending <= rd_issue;
            count   <= count + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (fire) out_idx <= out_idx + 1'b1;
            if (grad_acc && (grad_last != (beat_cnt == CNT_LAST))) err <= 1'b1;
            if (adv) begin
               beat_cnt <= beat_cnt + 1'b1;
               if (col_q == COL_LAST) begin
                  col_q <= '0;
                  if (row_q == ROW_LAST) begin
                     row_q <= '0;
                     ch_q  <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                  end else begin
                     row_q <= row_q + 1'b1;
                  end
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_flatten_stream_ctrl.sv
// Bench for flatten_stream_ctrl on the small 2x2x3 configuration: randomized forward/backward
// passes checked against an index-arithmetic model of the flatten ordering.
module tb_flatten_stream_ctrl;
   localparam int W  = 16;
   localparam int CH = 2;
   localparam int H  = 2;
   localparam int WD = 3;
   localparam int L  = CH * H * WD;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic          busy, done, err;
   logic          fwd_rd_en;
   logic [0:0]    fwd_rd_ch, fwd_rd_row;
   logic [1:0]    fwd_rd_col;
   logic [W-1:0]  fwd_rd_data = '0;
   logic          fcl_valid;
   logic          fcl_ready = 1'b0;
   logic [W-1:0]  fcl_data;
   logic [3:0]    fcl_idx;
   logic          fcl_last;
   logic          grad_valid = 1'b0;
   logic          grad_ready;
   logic [W-1:0]  grad_data = '0;
   logic          grad_last = 1'b0;
   logic          bwd_wr_en;
   logic [0:0]    bwd_wr_ch, bwd_wr_row;
   logic [1:0]    bwd_wr_col;
   logic [W-1:0]  bwd_wr_data;

   int checks = 0;
   int failures = 0;
   int base = 0;

   always #5 clk = ~clk;

   flatten_stream_ctrl #(.WIDTH(W), .CHANNELS(CH), .DIM3_WIDTH(WD), .DIM3_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .busy(busy), .done(done), .err(err),
      .fwd_rd_en(fwd_rd_en), .fwd_rd_ch(fwd_rd_ch), .fwd_rd_row(fwd_rd_row),
      .fwd_rd_col(fwd_rd_col), .fwd_rd_data(fwd_rd_data),
      .fcl_valid(fcl_valid), .fcl_ready(fcl_ready), .fcl_data(fcl_data),
      .fcl_idx(fcl_idx), .fcl_last(fcl_last),
      .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
      .grad_last(grad_last),
      .bwd_wr_en(bwd_wr_en), .bwd_wr_ch(bwd_wr_ch), .bwd_wr_row(bwd_wr_row),
      .bwd_wr_col(bwd_wr_col), .bwd_wr_data(bwd_wr_data)
   );

   // Buffer word at (ch,row,col), offset by a per-pass random base to exercise sign and width.
   function automatic logic [W-1:0] word(input int c, input int r, input int cl);
      return W'(base + 100 * c + 10 * r + cl);
   endfunction

   // Source memory with fixed 1-cycle read latency
   always @(posedge clk) begin
      if (fwd_rd_en) fwd_rd_data <= word(int'(fwd_rd_ch), int'(fwd_rd_row), int'(fwd_rd_col));
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_base();
      base = int'($urandom_range(40000)) - 20000;
   endtask

   // Forward pass. pct = percent of cycles with fcl_ready high; poke = cycle on which a
   // stray backward start is pulsed mid-pass; chain = issue the next start in the done cycle.
   task automatic run_fwd(input int pct, input bit do_start, input bit chain, input int poke);
      int k, cyc, issued, c, r, cl;
      bit prev_stall, rdy;
      logic [W-1:0] pd;
      logic [3:0] pi;
      if (do_start) begin
         new_base();
         start = 1'b1; mode = 1'b0;
         step();
         start = 1'b0;
      end
      chk("fwd_busy", busy, 1);
      chk("fwd_err_clear", err, 0);
      k = 0; cyc = 1; issued = 0; prev_stall = 0; pd = '0; pi = '0;
      while (k < L && cyc < 300) begin
         start = (cyc == poke);
         mode  = (cyc == poke);
         if (cyc == 1) chk("first_rd_en", fwd_rd_en, 1);
         if (cyc == 2) chk("first_beat_valid", fcl_valid, 1);
         if (fwd_rd_en) begin
            issued++;
            chk("fifo_occupancy_le2", (issued - k) <= 2, 1);
         end
         if (prev_stall) begin
            chk("hold_valid", fcl_valid, 1);
            chk("hold_data", fcl_data, pd);
            chk("hold_idx", fcl_idx, pi);
         end
         rdy = ($urandom_range(99) < pct);
         fcl_ready = rdy;
         if (fcl_valid && rdy) begin
            c = k / (H * WD); r = (k / WD) % H; cl = k % WD;
            chk("beat_data", fcl_data, word(c, r, cl));
            chk("beat_idx", fcl_idx, k);
            chk("beat_last", fcl_last, (k == L - 1));
            if (pct == 100 && k == L - 1) chk("last_beat_cycle", cyc, L + 1);
            k++;
         end
         prev_stall = fcl_valid && !rdy;
         pd = fcl_data; pi = fcl_idx;
         step();
         cyc++;
      end
      start = 1'b0; mode = 1'b0;
      chk("fwd_beat_count", k, L);
      chk("fwd_read_count", issued, L);
      chk("fwd_done", done, 1);
      chk("fwd_busy_end", busy, 0);
      chk("fwd_valid_end", fcl_valid, 0);
      fcl_ready = 1'b0;
      if (chain) begin
         new_base();
         start = 1'b1; mode = 1'b0;
         step();
         start = 1'b0;
         chk("chain_busy", busy, 1);
         chk("chain_done_pulse", done, 0);
      end else begin
         step();
         chk("done_one_cycle", done, 0);
      end
   endtask

   // Backward pass. last_pos = beat carrying grad_last; gap_pct = percent of idle cycles.
   task automatic run_bwd(input int last_pos, input int gap_pct);
      int k, cyc, pk;
      bit gv, pb, exp_err;
      logic [W-1:0] pdat;
      start = 1'b1; mode = 1'b1;
      step();
      start = 1'b0; mode = 1'b0;
      chk("bwd_busy", busy, 1);
      chk("bwd_grad_ready", grad_ready, 1);
      k = 0; cyc = 0; pb = 0; pk = 0; pdat = '0; exp_err = 0;
      while (k < L && cyc < 300) begin
         chk("bwd_wr_en", bwd_wr_en, pb);
         if (pb) begin
            chk("bwd_ch", bwd_wr_ch, pk / (H * WD));
            chk("bwd_row", bwd_wr_row, (pk / WD) % H);
            chk("bwd_col", bwd_wr_col, pk % WD);
            chk("bwd_data", bwd_wr_data, pdat);
         end
         chk("bwd_err", err, exp_err);
         gv = ($urandom_range(99) >= gap_pct);
         grad_valid = gv;
         grad_data  = W'($urandom);
         grad_last  = gv ? (k == last_pos) : 1'($urandom_range(1));
         pb = gv; pk = k; pdat = grad_data;
         if (gv) begin
            if ((k == last_pos) != (k == L - 1)) exp_err = 1;
            k++;
         end
         step();
         cyc++;
      end
      // Done cycle: FSM is idle, so this valid beat must be ignored
      grad_valid = 1'b1; grad_data = 16'h1234; grad_last = 1'b0;
      chk("bwd_beat_count", k, L);
      chk("bwd_final_wr_en", bwd_wr_en, 1);
      chk("bwd_final_ch", bwd_wr_ch, pk / (H * WD));
      chk("bwd_final_row", bwd_wr_row, (pk / WD) % H);
      chk("bwd_final_col", bwd_wr_col, pk % WD);
      chk("bwd_final_data", bwd_wr_data, pdat);
      chk("bwd_done", done, 1);
      chk("bwd_busy_end", busy, 0);
      chk("bwd_ready_end", grad_ready, 0);
      chk("bwd_err_end", err, exp_err);
      step();
      grad_valid = 1'b0;
      chk("idle_grad_no_write", bwd_wr_en, 0);
      chk("bwd_done_one_cycle", done, 0);
      chk("bwd_err_sticky", err, exp_err);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {busy, done, err, fwd_rd_en, fcl_valid, fcl_last, grad_ready, bwd_wr_en,
                fwd_rd_ch, fwd_rd_row, fwd_rd_col, bwd_wr_ch, bwd_wr_row, bwd_wr_col,
                fcl_idx, fcl_data, bwd_wr_data}, 0);
   endtask

   initial begin
      int i;
      #10000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      rst_n = 1'b0;
      step(); step();
      chk_all_zero("reset_outputs");
      rst_n = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      run_fwd(100, 1, 0, -1);
      run_fwd(50, 1, 0, -1);
      run_fwd(30, 1, 0, -1);

      run_bwd(L - 1, 0);
      run_bwd(L - 1, 40);
      run_bwd(5, 20);
      run_fwd(100, 1, 0, -1);

      // Reset while beat 4 is on the stream
      new_base();
      fcl_ready = 1'b1;
      start = 1'b1; mode = 1'b0;
      step();
      start = 1'b0;
      for (i = 0; i < 20 && !(fcl_valid && fcl_idx == 4'd4); i++) step();
      chk("reached_beat4", fcl_idx, 4);
      rst_n = 1'b0;
      step();
      chk_all_zero("midpass_reset_outputs");
      rst_n = 1'b1;
      fcl_ready = 1'b0;
      for (i = 0; i < 3; i++) begin
         step();
         chk("no_done_after_abort", {done, busy}, 0);
      end
      run_fwd(100, 1, 0, -1);

      run_fwd(100, 1, 1, 4);
      run_fwd(60, 0, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
